// File: rtl/jpeg_pkg.sv
// Shared constants and types for the JPEG RGB -> YCbCr colour converter.
package jpeg_pkg;

  localparam int COEF_FRAC = 14;          // Q2.14 coefficients
  localparam int COEF_W    = 20;          // signed coefficient width
  localparam int PROD_W    = 32;          // product / accumulator width
  localparam int COMP_W    = 8;           // unsigned RGB component width
  localparam int PIX_W     = 9;           // signed level-shifted output width
  localparam int ADDR_W    = 8;           // block buffer address width
  localparam int BLK_W     = 12;          // block coordinate width

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [PIX_W-1:0]  pix_t;

  // Rows: Y, Cb, Cr.  Columns: R, G, B.
  localparam coef_t COEF [3][3] = '{
    '{ 20'sh01323,  20'sh02591,  20'sh0074C},
    '{-20'sh00ACD, -20'sh01533,  20'sh02000},
    '{ 20'sh02000, -20'sh01ACC, -20'sh00534}
  };

  localparam prod_t ROUND    = prod_t'(1) <<< (COEF_FRAC - 1);
  localparam prod_t Y_OFFSET = prod_t'(128);
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  // Sideband that travels through the pipeline alongside each pixel.
  typedef struct packed {
    logic              bank;
    logic [ADDR_W-1:0] addr;
    logic              last;
  } tag_t;

  // Signed coefficient times unsigned component, full precision.
  function automatic prod_t coef_mul(input coef_t c, input logic [COMP_W-1:0] x);
    prod_t cw;
    prod_t xw;
    cw = prod_t'(c);
    xw = prod_t'({1'b0, x});
    return cw * xw;
  endfunction

  // Saturate a wide signed value into the 9-bit range -128..127.
  function automatic pix_t sat_pix(input prod_t v);
    if (v > prod_t'(127))       return pix_t'(127);
    else if (v < prod_t'(-128)) return pix_t'(-128);
    else                        return v[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/jpeg_rgb2ycbcr_dp.sv
// Three-stage colour-conversion datapath: multiply, sum+round, shift/offset/clamp.
// The valid bit and the bank/address/last tag ride along with the data.
module jpeg_rgb2ycbcr_dp
  import jpeg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  input  tag_t              in_tag_i,
  input  logic [COMP_W-1:0] in_r_i,
  input  logic [COMP_W-1:0] in_g_i,
  input  logic [COMP_W-1:0] in_b_i,
  output logic              out_valid_o,
  output tag_t              out_tag_o,
  output pix_t              out_y_o,
  output pix_t              out_cb_o,
  output pix_t              out_cr_o
);

  logic [COMP_W-1:0] comp [3];
  prod_t prod_q [3][3];
  prod_t sum_q  [3];
  pix_t  res_d  [3];
  logic  v1_q, v2_q;
  tag_t  t1_q, t2_q;

  assign comp = '{in_r_i, in_g_i, in_b_i};

  // Stage valids: cleared by reset so a reset drops everything in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v1_q <= in_valid_i;
      v2_q <= v1_q;
    end
  end

  // S1/S2 data and tags: products, then row sums with rounding.
  always_ff @(posedge clk) begin
    // NOTE: wide datapath registers have no reset; the valid bits alone qualify them.
    t1_q <= in_tag_i;
    t2_q <= t1_q;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        prod_q[i][j] <= coef_mul(COEF[i][j], comp[j]);
      end
      sum_q[i] <= prod_q[i][0] + prod_q[i][1] + prod_q[i][2] + ROUND;
    end
  end

  // S3 combinational part: drop fraction, level-shift Y, saturate.
  always_comb begin
    res_d[0] = sat_pix((sum_q[0] >>> COEF_FRAC) - Y_OFFSET);
    res_d[1] = sat_pix(sum_q[1] >>> COEF_FRAC);
    res_d[2] = sat_pix(sum_q[2] >>> COEF_FRAC);
  end

  // S3 output registers: visible at the block ports, so they reset to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_o <= 1'b0;
      out_tag_o   <= '0;
      out_y_o     <= '0;
      out_cb_o    <= '0;
      out_cr_o    <= '0;
    end else begin
      out_valid_o <= v2_q;
      if (v2_q) begin
        out_tag_o <= t2_q;
        out_y_o   <= res_d[0];
        out_cb_o  <= res_d[1];
        out_cr_o  <= res_d[2];
      end
    end
  end

endmodule

// File: rtl/jpeg_rgb2ycbcr.sv
// RGB -> YCbCr converter top: input handshake, pixel counter, ping-pong bank
// bookkeeping and block coordinates around the arithmetic datapath.
module jpeg_rgb2ycbcr
  import jpeg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              InEnable,
  output logic              InReady,
  input  logic [BLK_W-1:0]  InBlockX,
  input  logic [BLK_W-1:0]  InBlockY,
  input  logic [COMP_W-1:0] InR,
  input  logic [COMP_W-1:0] InG,
  input  logic [COMP_W-1:0] InB,
  output logic              OutWrite,
  output logic              OutWrBank,
  output logic [ADDR_W-1:0] OutAddress,
  output pix_t              OutY,
  output pix_t              OutCb,
  output pix_t              OutCr,
  output logic              OutValid,
  output logic              OutBank,
  output logic [BLK_W-1:0]  OutBlockX,
  output logic [BLK_W-1:0]  OutBlockY,
  input  logic              OutRelease
);

  logic [ADDR_W-1:0]       pix_cnt_q, pix_cnt_d;
  logic                    wr_bank_q, wr_bank_d;
  logic                    rd_bank_q, rd_bank_d;
  logic [1:0]              full_q, full_d;
  logic [1:0][BLK_W-1:0]   blk_x_q, blk_x_d;
  logic [1:0][BLK_W-1:0]   blk_y_q, blk_y_d;
  logic                    accept;
  logic                    dp_valid;
  tag_t                    in_tag, dp_tag;

  assign InReady = ~full_q[wr_bank_q];
  assign accept  = InEnable & InReady;
  assign in_tag  = '{bank: wr_bank_q, addr: pix_cnt_q, last: (pix_cnt_q == ADDR_LAST)};

  jpeg_rgb2ycbcr_dp u_dp (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (accept),
    .in_tag_i    (in_tag),
    .in_r_i      (InR),
    .in_g_i      (InG),
    .in_b_i      (InB),
    .out_valid_o (dp_valid),
    .out_tag_o   (dp_tag),
    .out_y_o     (OutY),
    .out_cb_o    (OutCb),
    .out_cr_o    (OutCr)
  );

  assign OutWrite   = dp_valid;
  assign OutWrBank  = dp_tag.bank;
  assign OutAddress = dp_tag.addr;
  assign OutValid   = full_q[rd_bank_q];
  assign OutBank    = rd_bank_q;
  assign OutBlockX  = blk_x_q[rd_bank_q];
  assign OutBlockY  = blk_y_q[rd_bank_q];

  // Next-state: pixel counter, write bank, coordinates, full flags, read bank.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    pix_cnt_d = pix_cnt_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    blk_x_d   = blk_x_q;
    blk_y_d   = blk_y_q;

    if (accept) begin
      pix_cnt_d = pix_cnt_q + 1'b1;
      if (pix_cnt_q == '0) begin
        blk_x_d[wr_bank_q] = InBlockX;
        blk_y_d[wr_bank_q] = InBlockY;
      end
      if (pix_cnt_q == ADDR_LAST) wr_bank_d = ~wr_bank_q;
    end

    // Last write of a block closes its bank; a release frees the offered bank.
    // The two never target the same bank, so both may apply in one cycle.
    if (dp_valid && dp_tag.last) full_d[dp_tag.bank] = 1'b1;
    if (OutRelease && full_q[rd_bank_q]) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  // Bookkeeping registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt_q <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= '0;
      blk_x_q   <= '0;
      blk_y_q   <= '0;
    end else begin
      pix_cnt_q <= pix_cnt_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      blk_x_q   <= blk_x_d;
      blk_y_q   <= blk_y_d;
    end
  end

endmodule
